// File: rtl/sm_icache_if.sv
// Fetch-side and memory-side signals of the sm_icache instruction cache.
//
// Handshake summary:
//   Fetch:  the CPU raises im_req with im_addr; the request is taken only in a
//           cycle where im_busy=0. im_busy stays high from the cycle after
//           acceptance through the cycle where im_drdy pulses. im_data is
//           valid only while im_drdy=1.
//   Memory: mem_req is a level that stays high for the whole burst, with
//           mem_addr stable. Each cycle with mem_rvalid=1 delivers one beat on
//           mem_rdata in ascending word order. There is no back-pressure;
//           idle cycles between beats are allowed.
interface sm_icache_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_drdy;
    logic [31:0] im_data;
    logic        im_busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // CPU fetch port plus instruction memory, as seen from outside the cache
    modport master (
        output im_req, im_addr, mem_rvalid, mem_rdata,
        input  im_drdy, im_data, im_busy, mem_req, mem_addr
    );

    // The cache itself
    modport slave (
        input  im_req, im_addr, mem_rvalid, mem_rdata,
        output im_drdy, im_data, im_busy, mem_req, mem_addr
    );
endinterface

// File: rtl/sm_icache.sv
// sm_icache: direct-mapped, read-only instruction cache with whole-line burst
// refill. When CACHE_EN=0 it passes each fetch through as a one-beat read.
// The optional macro SM_ICACHE_STATS_EN adds saturating hit and miss counters
// (hit_cnt, miss_cnt).
module sm_icache #(
    parameter int CACHE_EN   = 1,
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    sm_icache_if.slave  bus,
`ifdef SM_ICACHE_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    output logic [1:0]  dbg_state
);
    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 30 - OFF - IDX;
    localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REFILL = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      im_data_q, im_data_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [OFF-1:0]   beat_q, beat_d;
    logic             refill_flushed_q, refill_flushed_d;

    // Storage arrays hold no reset; the valid bits alone say what is usable.
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*LINE_WORDS];

    logic             data_we;
    logic             tag_we;
    logic             valid_set;
    logic             hit;
    logic [31:0]      rd_word;
    logic [IDX-1:0]   line_idx;
    logic [OFF-1:0]   word_off;
    logic [TAG_W-1:0] line_tag;
    logic             unused_addr_bits;

    assign line_idx         = addr_q[OFF+2 +: IDX];
    assign word_off         = addr_q[2 +: OFF];
    assign line_tag         = addr_q[31 -: TAG_W];
    assign unused_addr_bits = ^addr_q[1:0];

    assign hit     = (state_q == LOOKUP) && valid_q[line_idx]
                     && (tag_mem[line_idx] == line_tag);
    assign rd_word = data_mem[{line_idx, word_off}];

    // A hit answers combinationally in the LOOKUP cycle; a refill answers from im_data_q in RESP.
    assign bus.im_drdy  = hit || (state_q == RESP);
    assign bus.im_data  = hit ? rd_word : im_data_q;
    assign bus.im_busy  = (state_q != IDLE);
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign dbg_state    = state_q;

    // Next-state, refill sequencing and valid-bit maintenance
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        im_data_d        = im_data_q;
        mem_req_d        = mem_req_q;
        mem_addr_d       = mem_addr_q;
        valid_d          = valid_q;
        beat_d           = beat_q;
        refill_flushed_d = refill_flushed_q;
        data_we          = 1'b0;
        tag_we           = 1'b0;
        valid_set        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.im_req) begin
                    addr_d = bus.im_addr;
                    if (CACHE_EN != 0) begin
                        state_d = LOOKUP;
                    end else begin
                        state_d    = REFILL;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.im_addr[31:2], 2'b00};
                    end
                end
            end
            LOOKUP: begin
                if (hit) begin
                    im_data_d = rd_word;
                    state_d   = IDLE;
                end else begin
                    state_d          = REFILL;
                    mem_req_d        = 1'b1;
                    mem_addr_d       = {addr_q[31:OFF+2], {(OFF+2){1'b0}}};
                    beat_d           = '0;
                    refill_flushed_d = 1'b0;
                end
            end
            REFILL: begin
                // A flush seen at any point of the refill keeps the line invalid.
                if (flush) begin
                    refill_flushed_d = 1'b1;
                end
                if (bus.mem_rvalid) begin
                    if (CACHE_EN == 0) begin
                        im_data_d = bus.mem_rdata;
                        mem_req_d = 1'b0;
                        state_d   = RESP;
                    end else begin
                        data_we = 1'b1;
                        if (beat_q == word_off) begin
                            im_data_d = bus.mem_rdata;
                        end
                        beat_d = beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            tag_we    = 1'b1;
                            mem_req_d = 1'b0;
                            state_d   = RESP;
                            valid_set = !refill_flushed_q && !flush;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush && (CACHE_EN != 0)) begin
            valid_d = '0;
        end
        if (valid_set) begin
            valid_d[line_idx] = 1'b1;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            im_data_q        <= '0;
            mem_req_q        <= 1'b0;
            mem_addr_q       <= '0;
            valid_q          <= '0;
            beat_q           <= '0;
            refill_flushed_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            im_data_q        <= im_data_d;
            mem_req_q        <= mem_req_d;
            mem_addr_q       <= mem_addr_d;
            valid_q          <= valid_d;
            beat_q           <= beat_d;
            refill_flushed_q <= refill_flushed_d;
        end
    end

    // Tag and data array writes during refill
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{line_idx, beat_q}] <= bus.mem_rdata;
        end
        if (tag_we) begin
            tag_mem[line_idx] <= line_tag;
        end
    end

`ifdef SM_ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating counters bumped once per LOOKUP cycle
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP) begin
            if (hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end
            end else if (miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers; flush deliberately leaves them alone
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_sm_icache.sv
// Bench for sm_icache: a cached instance (dut0) driven from a vector table plus
// hand-written flush/reset sequences, and a pass-through instance (dut1).
`timescale 1ns/1ps
module tb_sm_icache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush0 = 1'b0;
    logic flush1 = 1'b0;
    logic [1:0] dbg0, dbg1;

    sm_icache_if b0();
    sm_icache_if b1();

`ifdef SM_ICACHE_STATS_EN
    logic [31:0] hit0, miss0, hit1, miss1;
`endif

    sm_icache #(.CACHE_EN(1), .LINE_WORDS(4), .LINES(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0), .bus(b0.slave),
`ifdef SM_ICACHE_STATS_EN
        .hit_cnt(hit0), .miss_cnt(miss0),
`endif
        .dbg_state(dbg0)
    );

    sm_icache #(.CACHE_EN(0), .LINE_WORDS(4), .LINES(16)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .bus(b1.slave),
`ifdef SM_ICACHE_STATS_EN
        .hit_cnt(hit1), .miss_cnt(miss1),
`endif
        .dbg_state(dbg1)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Burst memory model for dut0
    int          mem_gap = 0;
    int          m_beat = 0;
    int          m_gap = 0;
    int          m_bursts = 0;
    int          m_beats = 0;
    bit          m_serving = 1'b0;
    bit          m_wait_low = 1'b0;
    logic [31:0] m_base = '0;

    function automatic logic [31:0] backing(input logic [31:0] a);
        logic [31:0] low_words [4];
        low_words = '{32'h11, 32'h22, 32'h33, 32'h44};
        if (a < 32'h10) return low_words[a[3:2]];
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(posedge clk) begin
        b0.mem_rvalid <= 1'b0;
        if (rst) begin
            m_serving  = 1'b0;
            m_wait_low = 1'b0;
            b0.mem_rdata <= '0;
        end else begin
            if (m_wait_low && !b0.mem_req) m_wait_low = 1'b0;
            if (!m_serving && !m_wait_low && b0.mem_req) begin
                m_serving = 1'b1;
                m_beat    = 0;
                m_gap     = mem_gap;
                m_base    = b0.mem_addr;
                m_bursts++;
            end
            if (m_serving) begin
                if (m_gap > 0) begin
                    m_gap--;
                end else begin
                    b0.mem_rvalid <= 1'b1;
                    b0.mem_rdata  <= backing(m_base + 32'(4 * m_beat));
                    m_beat++;
                    m_beats++;
                    m_gap = mem_gap;
                    if (m_beat == 4) begin
                        m_serving  = 1'b0;
                        m_wait_low = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // One fetch on dut0; flush0 is pulsed in cycle flush_at (0 = request cycle).
    task automatic fetch(input logic [31:0] addr, input int flush_at,
                         output logic [31:0] data, output int lat,
                         output int mreq_cyc, output logic [31:0] maddr);
        int c;
        lat      = -1;
        mreq_cyc = -1;
        maddr    = '0;
        data     = '0;
        b0.im_req  = 1'b1;
        b0.im_addr = addr;
        flush0     = (flush_at == 0);
        c = 0;
        while (c < 200 && lat < 0) begin
            if (b0.mem_req && mreq_cyc < 0) begin
                mreq_cyc = c;
                maddr    = b0.mem_addr;
            end
            if (b0.im_drdy) begin
                lat  = c;
                data = b0.im_data;
            end
            step();
            c++;
            b0.im_req = 1'b0;
            flush0    = (flush_at == c);
        end
        flush0 = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          flush_at;
        int          gap;
        logic        hit;
        logic [31:0] exp_data;
        logic [31:0] exp_maddr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] data, maddr;
        int lat, mreq_cyc, bursts_before, beats_before, n_hit, n_miss;

        // Hit latency 1; miss latency 3 + 4*(gap+1) with this memory model.
        vecs[0]  = '{32'h000, -1, 0, 1'b0, 32'h0000_0011, 32'h000, 7};
        vecs[1]  = '{32'h008, -1, 0, 1'b1, 32'h0000_0033, 32'h000, 1};
        vecs[2]  = '{32'h00C, -1, 0, 1'b1, 32'h0000_0044, 32'h000, 1};
        vecs[3]  = '{32'h100, -1, 1, 1'b0, 32'hC0DE_0100, 32'h100, 11};
        vecs[4]  = '{32'h10C, -1, 0, 1'b1, 32'hC0DE_010C, 32'h000, 1};
        vecs[5]  = '{32'h004, -1, 0, 1'b0, 32'h0000_0022, 32'h000, 7};
        vecs[6]  = '{32'h004, -1, 0, 1'b1, 32'h0000_0022, 32'h000, 1};
        vecs[7]  = '{32'h004,  0, 0, 1'b0, 32'h0000_0022, 32'h000, 7};
        vecs[8]  = '{32'h03C, -1, 2, 1'b0, 32'hC0DE_003C, 32'h030, 15};
        vecs[9]  = '{32'h034, -1, 0, 1'b1, 32'hC0DE_0034, 32'h000, 1};
        vecs[10] = '{32'h1FC, -1, 0, 1'b0, 32'hC0DE_01FC, 32'h1F0, 7};
        vecs[11] = '{32'h1F8, -1, 0, 1'b1, 32'hC0DE_01F8, 32'h000, 1};
        vecs[12] = '{32'h040,  4, 1, 1'b0, 32'hC0DE_0040, 32'h040, 11};
        vecs[13] = '{32'h040, -1, 0, 1'b0, 32'hC0DE_0040, 32'h040, 7};
        vecs[14] = '{32'h048,  1, 0, 1'b1, 32'hC0DE_0048, 32'h000, 1};
        vecs[15] = '{32'h048, -1, 0, 1'b0, 32'hC0DE_0048, 32'h040, 7};

        b0.im_req = 1'b0;  b0.im_addr = '0;
        b1.im_req = 1'b0;  b1.im_addr = '0;
        b1.mem_rvalid = 1'b0; b1.mem_rdata = '0;

        // Reset values
        rst = 1'b1;
        step(); step(); step();
        check("rst_drdy",     b0.im_drdy,  0);
        check("rst_data",     b0.im_data,  0);
        check("rst_busy",     b0.im_busy,  0);
        check("rst_mem_req",  b0.mem_req,  0);
        check("rst_mem_addr", b0.mem_addr, 0);
        check("rst_state",    dbg0,        0);
        check("rst_pt_busy",  b1.im_busy,  0);
        check("rst_pt_req",   b1.mem_req,  0);
        rst = 1'b0;
        step();

        // Table-driven fetches on the cached instance
        n_hit = 0;
        n_miss = 0;
        for (int i = 0; i < 16; i++) begin
            mem_gap = vecs[i].gap;
            bursts_before = m_bursts;
            exp_q.push_back(vecs[i].exp_data);
            fetch(vecs[i].addr, vecs[i].flush_at, data, lat, mreq_cyc, maddr);
            check($sformatf("v%0d_data", i), data, exp_q.pop_front());
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_mreq_cyc", i), mreq_cyc, vecs[i].hit ? -1 : 2);
            check($sformatf("v%0d_maddr", i), maddr, vecs[i].exp_maddr);
            check($sformatf("v%0d_bursts", i), m_bursts - bursts_before, vecs[i].hit ? 0 : 1);
            if (vecs[i].hit) n_hit++;
            else n_miss++;
        end
`ifdef SM_ICACHE_STATS_EN
        check("stats_hit",  hit0,  n_hit);
        check("stats_miss", miss0, n_miss);
        check("stats_pt_hit", hit1, 0);
`endif

        // Reset after two of four beats aborts the refill
        mem_gap = 0;
        b0.im_req = 1'b1;
        b0.im_addr = 32'h0;
        step();
        b0.im_req = 1'b0;
        step();
        step();
        step();
        check("rr_state_refill", dbg0, 2);
        check("rr_mem_req_mid",  b0.mem_req, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_mem_req", b0.mem_req, 0);
        check("rr_busy",    b0.im_busy, 0);
        check("rr_drdy",    b0.im_drdy, 0);
        check("rr_data",    b0.im_data, 0);
        check("rr_rvalid",  b0.mem_rvalid, 0);
        step();
        beats_before = m_beats;
        fetch(32'h0, -1, data, lat, mreq_cyc, maddr);
        check("rr_refetch_data",  data, 32'h11);
        check("rr_refetch_lat",   lat, 7);
        check("rr_refetch_maddr", maddr, 32'h0);
        check("rr_refetch_beats", m_beats - beats_before, 4);

        // Pass-through instance: one beat per fetch, held request ignored while busy
        b1.im_req = 1'b1;
        b1.im_addr = 32'h0E;
        step();
        flush1 = 1'b1;
        check("pt_mem_req",  b1.mem_req,  1);
        check("pt_mem_addr", b1.mem_addr, 32'h0C);
        check("pt_busy",     b1.im_busy,  1);
        b1.im_addr = 32'h40;
        b1.mem_rvalid = 1'b1;
        b1.mem_rdata = 32'hABCD;
        step();
        flush1 = 1'b0;
        b1.mem_rvalid = 1'b0;
        check("pt_drdy",     b1.im_drdy, 1);
        check("pt_data",     b1.im_data, 32'hABCD);
        check("pt_req_drop", b1.mem_req, 0);
        step();
        b1.im_req = 1'b0;
        check("pt_idle_busy", b1.im_busy, 0);
        check("pt_idle_drdy", b1.im_drdy, 0);
        step();
        check("pt_no_accept", b1.mem_req, 0);
        b1.im_req = 1'b1;
        b1.im_addr = 32'h0C;
        step();
        b1.im_req = 1'b0;
        check("pt2_mem_req",  b1.mem_req,  1);
        check("pt2_mem_addr", b1.mem_addr, 32'h0C);
        step();
        check("pt2_wait_drdy", b1.im_drdy, 0);
        b1.mem_rvalid = 1'b1;
        b1.mem_rdata = 32'h1234;
        step();
        b1.mem_rvalid = 1'b0;
        check("pt2_drdy", b1.im_drdy, 1);
        check("pt2_data", b1.im_data, 32'h1234);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sm_icache.md
Name: sm_icache

Overview:
- Direct-mapped, read-only instruction cache between the sr_cpu fetch port and the instruction memory.
- Drives `im_drdy`/`im_data` into the CPU, so the CPU advances `pc` only when a fetch completes.
- On a miss it refills one whole line from a burst memory port.
- Instantiated inside sm_top under the `CACHE_EN` parameter.

Parameters:
- CACHE_EN, 1, 1 = cache active; 0 = pass-through (single-word fetch per request, no storage used).
- LINE_WORDS, 4, 32-bit words per line; power of two, >= 2.
- LINES, 16, number of lines; power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  one-cycle pulse: invalidate all lines.
- im_req  in  1  fetch request; sampled only when im_busy=0.
- im_addr  in  32  byte address of fetch; bits [1:0] ignored.
- im_drdy  out  1  one-cycle pulse: im_data valid for the accepted request.
- im_data  out  32  fetched instruction word.
- im_busy  out  1  high from acceptance until the cycle im_drdy is high, inclusive.
- mem_req  out  1  burst read request, level.
- mem_addr  out  32  burst start address, stable while mem_req=1.
- mem_rvalid  in  1  memory beat valid.
- mem_rdata  in  32  memory beat data.

Behaviour:
- Address split (CACHE_EN=1):
  - OFF = log2(LINE_WORDS) word-offset bits at [OFF+1:2].
  - IDX = log2(LINES) index bits above OFF.
  - Tag = remaining upper bits.
- Reset: im_drdy=0, im_data=0, im_busy=0, mem_req=0, mem_addr=0, all valid bits=0, FSM=IDLE, beat counter=0. Tag/data arrays are not reset.
- FSM states: IDLE, LOOKUP, REFILL, RESP.
- IDLE, im_req=1: latch im_addr, im_busy=1, go to LOOKUP.
- LOOKUP, hit (valid && tag match):
  - im_data = array word, im_drdy=1 in this same cycle, im_busy=0 at cycle end, go to IDLE.
  - Hit latency: request at cycle N, im_drdy at N+1.
- LOOKUP, miss:
  - Go to REFILL.
  - mem_req=1 from the next cycle; mem_addr = latched address with bits [OFF+1:0] cleared.
- REFILL:
  - Memory returns exactly LINE_WORDS beats in ascending word order; gaps of any length allowed.
  - Each beat is written to word[beat_cnt] of the indexed line; beat_cnt increments and wraps to 0 after the last beat.
  - The requested word is captured into im_data as its beat arrives.
  - Last beat: write tag, set valid (unless a flush occurred during this refill), mem_req=0 next cycle, go to RESP.
- RESP: im_drdy=1 for one cycle, then IDLE.
  - Miss latency = 1 + 1 + beat latency + 1 cycles.
- Rules:
  - im_req while im_busy=1 is ignored.
  - Back-to-back: a new request may be accepted in the cycle after im_drdy.
- flush:
  - In IDLE/LOOKUP/RESP: all valid bits clear at the next edge.
  - A LOOKUP in the same cycle as flush uses the pre-flush valid state.
  - During REFILL: valid bits clear, the refill runs to completion and returns data, but the line is not validated.
- rst mid-refill: abort immediately. mem_req=0 next cycle; later beats are ignored until a new refill starts (the memory model must also be reset).
- CACHE_EN=0: every request goes IDLE -> REFILL with one beat, mem_addr = im_addr & ~3, then RESP. flush has no effect.

Optional Feature:
- Macro: `SM_ICACHE_STATS_EN`.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Reset to 0; increment in the LOOKUP cycle on hit/miss respectively; saturate at 0xFFFFFFFF; not cleared by flush.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
All cases use LINE_WORDS=4, LINES=16 unless stated.
1. Reset, then im_req addr 0x00; memory returns 0x11, 0x22, 0x33, 0x44 with 0 gaps -> mem_req at cycle+2 with mem_addr 0x00; im_drdy with im_data 0x11 one cycle after the 4th beat; miss_cnt=1.
2. Then im_req addr 0x08 -> im_drdy on the next cycle, im_data 0x33, mem_req stays 0; hit_cnt=1.
3. im_req 0x100 (same index 0, new tag) -> refill at mem_addr 0x100; then im_req 0x04 -> miss again, refill at mem_addr 0x00.
4. Line 0x00 valid, flush pulse, then im_req 0x04 -> miss. Separately, flush during refill of 0x40, then im_req 0x40 -> miss again.
5. rst asserted after 2 of 4 beats -> mem_req=0 and im_busy=0 next cycle; im_req 0x00 after reset -> full miss with 4 beats.
6. CACHE_EN=0, im_req 0x0E -> mem_addr 0x0C, single beat 0xABCD -> im_drdy with 0xABCD; repeating 0x0C issues a new mem_req.
